// File: rtl/axi_stream_strip_header_pkg.sv
// Shared definitions for the stream header strip/insert datapath.
// Holds the stream widths, the FSM state encoding, the payload beat struct,
// and the conversions between byte enables and byte counts.
package axi_stream_strip_header_pkg;

   localparam int unsigned DATA_WD      = 32;
   localparam int unsigned DATA_BYTE_WD = DATA_WD / 8;
   localparam int unsigned BYTE_CNT_WD  = $clog2(DATA_BYTE_WD);
   // Wide enough to hold a byte count of 0..DATA_BYTE_WD inclusive
   localparam int unsigned CNT_WD       = $clog2(DATA_BYTE_WD + 1);

   typedef logic [DATA_WD-1:0]      data_t;
   typedef logic [DATA_BYTE_WD-1:0] keep_t;
   typedef logic [CNT_WD-1:0]       cnt_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_HEAD  = 2'd1,
      ST_BODY  = 2'd2,
      ST_FLUSH = 2'd3
   } state_t;

   typedef struct packed {
      data_t data;
      keep_t keep;
      logic  last;
   } beat_t;

   // Number of set byte enables
   function automatic cnt_t keep_to_cnt(input keep_t keep);
      cnt_t c;
      c = '0;
      for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
         c = c + cnt_t'(keep[i]);
      end
      return c;
   endfunction

   // Left-aligned (MSB-first) contiguous byte enables for c bytes
   function automatic keep_t cnt_to_keep_left(input cnt_t c);
      keep_t k;
      k = '0;
      for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
         k[DATA_BYTE_WD-1-i] = (i < 32'(c));
      end
      return k;
   endfunction

   // Right-aligned contiguous byte enables for c bytes
   function automatic keep_t cnt_to_keep_right(input cnt_t c);
      keep_t k;
      k = '0;
      for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
         k[i] = (i < 32'(c));
      end
      return k;
   endfunction

   // Expand byte enables into a bit mask
   function automatic data_t keep_to_mask(input keep_t k);
      data_t m;
      m = '0;
      for (int unsigned i = 0; i < DATA_BYTE_WD; i++) begin
         m[8*i +: 8] = {8{k[i]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/axi_stream_strip_header_shifter.sv
// axis_byte_shifter: combinational byte realignment for header stripping.
// Ports:
//   tail      held left-aligned leftover bytes of the previous beat
//   beat/keep current input beat and its byte enables
//   n         header length in bytes (1..DATA_BYTE_WD)
//   hdr_*     upper min(c,n) bytes of the beat, right-aligned
//   cat_*     {tail, upper bytes of beat}, left-aligned, masked to keep
//   rem_*     bytes of the beat after the first n, left-aligned
module axis_byte_shifter
   import axi_stream_strip_header_pkg::*;
(
   input  logic [DATA_WD-1:0]      tail,
   input  logic [DATA_WD-1:0]      beat,
   input  logic [DATA_BYTE_WD-1:0] keep,
   input  logic [CNT_WD-1:0]       n,
   output logic [DATA_WD-1:0]      hdr_data,
   output logic [DATA_BYTE_WD-1:0] hdr_keep,
   output logic [DATA_WD-1:0]      cat_data,
   output logic [DATA_BYTE_WD-1:0] cat_keep,
   output logic [DATA_WD-1:0]      rem_data,
   output logic [DATA_BYTE_WD-1:0] rem_keep,
   output logic [CNT_WD-1:0]       rem_cnt
);

   int unsigned c_i;
   int unsigned n_i;
   int unsigned h_i;
   int unsigned r_i;

   // Byte counts, then shifts; shifting by the full width yields zero,
   // which is what makes N=DATA_BYTE_WD a pass-through with an empty tail.
   always_comb begin
      c_i = 32'(keep_to_cnt(keep));
      n_i = 32'(n);
      h_i = (c_i < n_i) ? c_i : n_i;
      r_i = (c_i > n_i) ? (c_i - n_i) : 32'd0;

      hdr_data = beat >> (8 * (DATA_BYTE_WD - h_i));
      hdr_keep = cnt_to_keep_right(cnt_t'(h_i));

      cat_keep = cnt_to_keep_left(cnt_t'(DATA_BYTE_WD - n_i + h_i));
      cat_data = (tail | (beat >> (8 * (DATA_BYTE_WD - n_i)))) & keep_to_mask(cat_keep);

      rem_cnt  = cnt_t'(r_i);
      rem_keep = cnt_to_keep_left(rem_cnt);
      rem_data = (beat << (8 * n_i)) & keep_to_mask(rem_keep);
   end

endmodule

// File: rtl/axi_stream_strip_header.sv
// axi_stream_strip_header: splits the first N bytes of each AXI-Stream packet
// onto a header side port (right-aligned) and re-packs the remaining payload
// MSB-first on the output stream.
// Ports:
//   clk, rst                         clock, async active-high reset
//   valid_in/ready_in/data_in/keep_in/last_in       input stream
//   valid_out/ready_out/data_out/keep_out/last_out  payload stream
//   valid_strip/ready_strip/byte_strip_cnt          per-packet N = cnt+1
//   valid_header/ready_header/data_header/keep_header  header side port
module axi_stream_strip_header
   import axi_stream_strip_header_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_in,
   output logic                    ready_in,
   input  logic [DATA_WD-1:0]      data_in,
   input  logic [DATA_BYTE_WD-1:0] keep_in,
   input  logic                    last_in,
   output logic                    valid_out,
   input  logic                    ready_out,
   output logic [DATA_WD-1:0]      data_out,
   output logic [DATA_BYTE_WD-1:0] keep_out,
   output logic                    last_out,
   input  logic                    valid_strip,
   output logic                    ready_strip,
   input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
   output logic                    valid_header,
   input  logic                    ready_header,
   output logic [DATA_WD-1:0]      data_header,
   output logic [DATA_BYTE_WD-1:0] keep_header
);

   state_t state;
   state_t state_nxt;

   cnt_t  n_reg;
   data_t tail_reg;
   keep_t tail_keep_reg;
   beat_t out_reg;

   logic  out_free;
   logic  hdr_free;
   logic  in_take;
   logic  strip_take;
   logic  hdr_load;
   logic  tail_load;
   logic  out_load;
   beat_t out_nxt;

   data_t sh_hdr_data;
   keep_t sh_hdr_keep;
   data_t sh_cat_data;
   keep_t sh_cat_keep;
   data_t sh_rem_data;
   keep_t sh_rem_keep;
   cnt_t  sh_rem_cnt;

   axis_byte_shifter u_shifter (
      .tail     (tail_reg),
      .beat     (data_in),
      .keep     (keep_in),
      .n        (n_reg),
      .hdr_data (sh_hdr_data),
      .hdr_keep (sh_hdr_keep),
      .cat_data (sh_cat_data),
      .cat_keep (sh_cat_keep),
      .rem_data (sh_rem_data),
      .rem_keep (sh_rem_keep),
      .rem_cnt  (sh_rem_cnt)
   );

   assign out_free   = !valid_out || ready_out;
   assign hdr_free   = !valid_header || ready_header;
   assign in_take    = valid_in && ready_in;
   assign strip_take = valid_strip && ready_strip;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a last beat leaving bytes beyond the header length
   // needs one extra FLUSH beat
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (strip_take) state_nxt = ST_HEAD;
         end
         ST_HEAD: begin
            if (in_take) state_nxt = last_in ? ST_IDLE : ST_BODY;
         end
         ST_BODY: begin
            if (in_take && last_in) begin
               state_nxt = (sh_rem_cnt != '0) ? ST_FLUSH : ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (out_free) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Handshake readies and datapath load controls.
   // The first beat may also produce a payload beat, so HEAD waits for both
   // the header and the output register to be free (or draining).
   always_comb begin
      ready_in    = 1'b0;
      ready_strip = 1'b0;
      hdr_load    = 1'b0;
      tail_load   = 1'b0;
      out_load    = 1'b0;
      out_nxt     = '0;
      case (state)
         ST_IDLE: begin
            ready_strip = !rst;
         end
         ST_HEAD: begin
            ready_in = hdr_free && out_free;
            if (valid_in && ready_in) begin
               hdr_load  = 1'b1;
               tail_load = 1'b1;
               if (last_in && (sh_rem_cnt != '0)) begin
                  out_load     = 1'b1;
                  out_nxt.data = sh_rem_data;
                  out_nxt.keep = sh_rem_keep;
                  out_nxt.last = 1'b1;
               end
            end
         end
         ST_BODY: begin
            ready_in = out_free;
            if (valid_in && ready_in) begin
               tail_load    = 1'b1;
               out_load     = 1'b1;
               out_nxt.data = sh_cat_data;
               out_nxt.keep = sh_cat_keep;
               out_nxt.last = last_in && (sh_rem_cnt == '0);
            end
         end
         ST_FLUSH: begin
            if (out_free) begin
               out_load     = 1'b1;
               out_nxt.data = tail_reg;
               out_nxt.keep = tail_keep_reg;
               out_nxt.last = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Header length and tail holding registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_reg         <= '0;
         tail_reg      <= '0;
         tail_keep_reg <= '0;
      end else begin
         if (strip_take) n_reg <= cnt_t'(byte_strip_cnt) + cnt_t'(1);
         if (tail_load) begin
            tail_reg      <= sh_rem_data;
            tail_keep_reg <= sh_rem_keep;
         end
      end
   end

   // Header side-port register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_header <= 1'b0;
         data_header  <= '0;
         keep_header  <= '0;
      end else if (hdr_load) begin
         valid_header <= 1'b1;
         data_header  <= sh_hdr_data;
         keep_header  <= sh_hdr_keep;
      end else if (ready_header) begin
         valid_header <= 1'b0;
      end
   end

   // Payload output register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         out_reg   <= '0;
      end else if (out_load) begin
         valid_out <= 1'b1;
         out_reg   <= out_nxt;
      end else if (ready_out) begin
         valid_out <= 1'b0;
      end
   end

   assign data_out = out_reg.data;
   assign keep_out = out_reg.keep;
   assign last_out = out_reg.last;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Scoreboard bench for axi_stream_strip_header: a byte-level model pushes the
// expected header and payload beats per packet; a monitor pops and compares.
module tb_axi_stream_strip_header;
   import axi_stream_strip_header_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic        ready_in;
   logic [31:0] data_in;
   logic [3:0]  keep_in;
   logic        last_in;
   logic        valid_out;
   logic        ready_out;
   logic [31:0] data_out;
   logic [3:0]  keep_out;
   logic        last_out;
   logic        valid_strip;
   logic        ready_strip;
   logic [1:0]  byte_strip_cnt;
   logic        valid_header;
   logic        ready_header;
   logic [31:0] data_header;
   logic [3:0]  keep_header;

   always #5 clk = ~clk;

   axi_stream_strip_header dut (
      .clk            (clk),
      .rst            (rst),
      .valid_in       (valid_in),
      .ready_in       (ready_in),
      .data_in        (data_in),
      .keep_in        (keep_in),
      .last_in        (last_in),
      .valid_out      (valid_out),
      .ready_out      (ready_out),
      .data_out       (data_out),
      .keep_out       (keep_out),
      .last_out       (last_out),
      .valid_strip    (valid_strip),
      .ready_strip    (ready_strip),
      .byte_strip_cnt (byte_strip_cnt),
      .valid_header   (valid_header),
      .ready_header   (ready_header),
      .data_header    (data_header),
      .keep_header    (keep_header)
   );

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic        l;
   } exp_beat_t;

   exp_beat_t out_q[$];
   exp_beat_t hdr_q[$];

   int n_checks = 0;
   int n_pass   = 0;
   bit mon_en   = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, act, exp);
   endtask

   // Byte-level reference: header = first min(N,len) bytes right-aligned,
   // payload = remaining bytes packed MSB-first into full beats.
   task automatic model_packet(input int n, input byte unsigned b[$]);
      int        len;
      int        hc;
      exp_beat_t e;
      len = b.size();
      hc  = (len < n) ? len : n;
      e.d = '0;
      e.l = 1'b0;
      for (int i = 0; i < hc; i++) e.d = {e.d[23:0], b[i]};
      e.k = 4'((1 << hc) - 1);
      hdr_q.push_back(e);
      for (int i = n; i < len; i += 4) begin
         e.d = '0;
         e.k = '0;
         for (int j = 0; j < 4; j++) begin
            if (i + j < len) begin
               e.d[31-8*j -: 8] = b[i+j];
               e.k[3-j]         = 1'b1;
            end
         end
         e.l = (i + 4 >= len);
         out_q.push_back(e);
      end
   endtask

   task automatic do_strip(input int n);
      bit hs;
      hs             = 1'b0;
      valid_strip    = 1'b1;
      byte_strip_cnt = 2'(n - 1);
      for (int t = 0; t < 200 && !hs; t++) begin
         @(negedge clk);
         hs = ready_strip;
         @(posedge clk);
         #1;
      end
      if (!hs) check_eq("strip_hs_timeout", 64'(ready_strip), 64'd1);
      valid_strip    = 1'b0;
      byte_strip_cnt = 2'($urandom);
   endtask

   task automatic do_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      bit hs;
      hs       = 1'b0;
      valid_in = 1'b1;
      data_in  = d;
      keep_in  = k;
      last_in  = l;
      for (int t = 0; t < 200 && !hs; t++) begin
         @(negedge clk);
         hs = ready_in;
         @(posedge clk);
         #1;
      end
      if (!hs) check_eq("in_hs_timeout", 64'(ready_in), 64'd1);
      valid_in = 1'b0;
      data_in  = $urandom;
      keep_in  = '0;
      last_in  = 1'b0;
   endtask

   // Hold both output readies low; the held payload beat must block input
   task automatic stall3();
      ready_out    = 1'b0;
      ready_header = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("stall_ready_in", 64'(ready_in), 64'd0);
         @(posedge clk);
         #1;
      end
      ready_out    = 1'b1;
      ready_header = 1'b1;
   endtask

   task automatic send_packet(input int n, input byte unsigned b[$], input int stall_at);
      int          nbeats;
      logic [31:0] d;
      logic [3:0]  k;
      model_packet(n, b);
      do_strip(n);
      nbeats = (b.size() + 3) / 4;
      for (int bi = 0; bi < nbeats; bi++) begin
         d = '0;
         k = '0;
         for (int j = 0; j < 4; j++) begin
            if (bi * 4 + j < b.size()) begin
               d[31-8*j -: 8] = b[bi*4+j];
               k[3-j]         = 1'b1;
            end
         end
         do_beat(d, k, bi == nbeats - 1);
         if (bi == stall_at) stall3();
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 300 && (out_q.size() != 0 || hdr_q.size() != 0); t++) @(posedge clk);
      #1;
      check_eq("out_q_empty", 64'(out_q.size()), 64'd0);
      check_eq("hdr_q_empty", 64'(hdr_q.size()), 64'd0);
   endtask

   // Monitor: compare on handshakes, check held outputs stay stable
   logic        p_out_stall;
   logic        p_hdr_stall;
   logic [31:0] p_data_out;
   logic [3:0]  p_keep_out;
   logic        p_last_out;
   logic [31:0] p_data_hdr;

   always @(negedge clk) begin
      exp_beat_t e;
      if (mon_en) begin
         if (p_out_stall) begin
            check_eq("hold_valid_out", 64'(valid_out), 64'd1);
            check_eq("hold_data_out", 64'(data_out), 64'(p_data_out));
            check_eq("hold_keep_out", 64'(keep_out), 64'(p_keep_out));
            check_eq("hold_last_out", 64'(last_out), 64'(p_last_out));
         end
         if (p_hdr_stall) begin
            check_eq("hold_valid_hdr", 64'(valid_header), 64'd1);
            check_eq("hold_data_hdr", 64'(data_header), 64'(p_data_hdr));
         end
         if (valid_out && ready_out) begin
            if (out_q.size() == 0) check_eq("unexpected_out", 64'(valid_out), 64'd0);
            else begin
               e = out_q.pop_front();
               check_eq("data_out", 64'(data_out), 64'(e.d));
               check_eq("keep_out", 64'(keep_out), 64'(e.k));
               check_eq("last_out", 64'(last_out), 64'(e.l));
            end
         end
         if (valid_header && ready_header) begin
            if (hdr_q.size() == 0) check_eq("unexpected_hdr", 64'(valid_header), 64'd0);
            else begin
               e = hdr_q.pop_front();
               check_eq("data_header", 64'(data_header), 64'(e.d));
               check_eq("keep_header", 64'(keep_header), 64'(e.k));
            end
         end
         p_out_stall = valid_out && !ready_out;
         p_hdr_stall = valid_header && !ready_header;
      end else begin
         p_out_stall = 1'b0;
         p_hdr_stall = 1'b0;
      end
      p_data_out = data_out;
      p_keep_out = keep_out;
      p_last_out = last_out;
      p_data_hdr = data_header;
   end

   initial begin
      byte unsigned b[$];
      int           nb;
      int           c;
      rst            = 1'b1;
      valid_in       = 1'b0;
      data_in        = '0;
      keep_in        = '0;
      last_in        = 1'b0;
      ready_out      = 1'b1;
      valid_strip    = 1'b0;
      byte_strip_cnt = '0;
      ready_header   = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_valid_out", 64'(valid_out), 64'd0);
      check_eq("rst_valid_header", 64'(valid_header), 64'd0);
      check_eq("rst_last_out", 64'(last_out), 64'd0);
      check_eq("rst_ready_in", 64'(ready_in), 64'd0);
      check_eq("rst_data_out", 64'(data_out), 64'd0);
      check_eq("rst_keep_out", 64'(keep_out), 64'd0);
      check_eq("rst_data_header", 64'(data_header), 64'd0);
      check_eq("rst_keep_header", 64'(keep_header), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_ready_strip", 64'(ready_strip), 64'd1);
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      send_packet(2, b, -1);
      b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33};
      send_packet(1, b, -1);
      b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_packet(4, b, -1);
      b = '{8'hAA, 8'hBB, 8'hCC};
      send_packet(3, b, -1);
      @(negedge clk);
      check_eq("single_beat_ready_strip", 64'(ready_strip), 64'd1);
      drain();

      // Random packets, 10..17 beats, stalled mid-packet
      for (int p = 0; p < 6; p++) begin
         nb = $urandom_range(17, 10);
         c  = $urandom_range(4, 1);
         b  = {};
         for (int i = 0; i < (nb - 1) * 4 + c; i++) b.push_back(8'($urandom_range(255, 0)));
         send_packet($urandom_range(4, 1), b, 4);
      end
      drain();

      // Reset pulsed mid-packet with held outputs
      mon_en       = 1'b0;
      ready_out    = 1'b0;
      ready_header = 1'b0;
      do_strip(3);
      do_beat($urandom, 4'b1111, 1'b0);
      do_beat($urandom, 4'b1111, 1'b0);
      check_eq("pre_rst_valid_out", 64'(valid_out), 64'd1);
      check_eq("pre_rst_valid_header", 64'(valid_header), 64'd1);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_valid_out", 64'(valid_out), 64'd0);
      check_eq("mid_rst_valid_header", 64'(valid_header), 64'd0);
      @(posedge clk);
      #1;
      rst          = 1'b0;
      ready_out    = 1'b1;
      ready_header = 1'b1;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      b = {};
      for (int i = 0; i < 11; i++) b.push_back(8'($urandom_range(255, 0)));
      send_packet(2, b, -1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
